// File: rtl/bus_scheduler.sv
// Time-division bus scheduler: one CPU bus cycle per frame, the rest of the
// frame shared round-robin between the video and SPI DMA requesters.
module bus_scheduler #(
  parameter int FRAME_CYCLES    = 64,
  parameter int MAX_XFER_CYCLES = 5
) (
  input  logic                            sys_clock_i,
  input  logic                            sys_reset_n_i,
  input  logic                            cpu_en_i,
  input  logic                            cpu_done_strobe_i,
  output logic                            cpu_grant_o,
  input  logic                            video_req_i,
  input  logic                            video_done_i,
  output logic                            video_grant_o,
  input  logic                            spi_req_i,
  input  logic                            spi_done_i,
  output logic                            spi_grant_o,
  output logic [1:0]                      owner_o,
  output logic [$clog2(FRAME_CYCLES)-1:0] frame_count_o,
  output logic                            overrun_o
);

  localparam int CW         = $clog2(FRAME_CYCLES);
  localparam int LAST_START = FRAME_CYCLES - 1 - MAX_XFER_CYCLES;

  localparam logic [CW-1:0] FRAME_LAST_C = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] LAST_START_C = CW'(LAST_START);

  localparam logic LAST_VIDEO = 1'b0;
  localparam logic LAST_SPI   = 1'b1;

  // Encoding doubles as the owner_o code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU   = 2'd1,
    ST_VIDEO = 2'd2,
    ST_SPI   = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_frame_count;
  logic            r_cpu_grant;
  logic            r_video_grant;
  logic            r_spi_grant;
  logic            r_overrun;
  logic            r_cpu_pending;
  logic            r_last_dma;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_frame_count_nxt;
  logic            w_cpu_grant_nxt;
  logic            w_overrun_nxt;
  logic            w_cpu_pending_nxt;
  logic            w_last_dma_nxt;
  logic            w_slot;
  logic            w_dma_window;
  logic            w_dma_done;

  // Next-state and next-output logic for the bus ownership FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_cpu_grant_nxt   = 1'b0;
    w_overrun_nxt     = r_overrun;
    w_cpu_pending_nxt = r_cpu_pending;
    w_last_dma_nxt    = r_last_dma;
    w_frame_count_nxt = (r_frame_count == FRAME_LAST_C) ? {CW{1'b0}}
                                                        : r_frame_count + CW'(1);
    w_slot            = cpu_en_i && (r_frame_count == FRAME_LAST_C);
    w_dma_window      = (r_frame_count <= LAST_START_C);
    w_dma_done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_slot) begin
          w_state_nxt     = ST_CPU;
          w_cpu_grant_nxt = 1'b1;
        end else if (w_dma_window && (video_req_i || spi_req_i)) begin
          // Tie goes to whichever requester did not win last time.
          if (video_req_i && (!spi_req_i || (r_last_dma == LAST_SPI))) begin
            w_state_nxt    = ST_VIDEO;
            w_last_dma_nxt = LAST_VIDEO;
          end else begin
            w_state_nxt    = ST_SPI;
            w_last_dma_nxt = LAST_SPI;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CPU: begin
        if (cpu_done_strobe_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CPU;
        end
      end
      ST_VIDEO, ST_SPI: begin
        w_dma_done = (r_state == ST_VIDEO) ? video_done_i : spi_done_i;
        if (w_dma_done) begin
          // A deferred (or coincident) CPU slot is served straight away.
          if (r_cpu_pending || w_slot) begin
            w_state_nxt       = ST_CPU;
            w_cpu_grant_nxt   = 1'b1;
            w_cpu_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_slot) begin
          w_cpu_pending_nxt = 1'b1;
          w_overrun_nxt     = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, frame counter and registered outputs.
  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) begin
      r_state       <= ST_IDLE;
      r_frame_count <= {CW{1'b0}};
      r_cpu_grant   <= 1'b0;
      r_video_grant <= 1'b0;
      r_spi_grant   <= 1'b0;
      r_overrun     <= 1'b0;
      r_cpu_pending <= 1'b0;
      r_last_dma    <= LAST_SPI;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_cpu_grant   <= w_cpu_grant_nxt;
      r_video_grant <= (w_state_nxt == ST_VIDEO);
      r_spi_grant   <= (w_state_nxt == ST_SPI);
      r_overrun     <= w_overrun_nxt;
      r_cpu_pending <= w_cpu_pending_nxt;
      r_last_dma    <= w_last_dma_nxt;
    end
  end

  assign cpu_grant_o   = r_cpu_grant;
  assign video_grant_o = r_video_grant;
  assign spi_grant_o   = r_spi_grant;
  assign owner_o       = r_state;
  assign frame_count_o = r_frame_count;
  assign overrun_o     = r_overrun;

endmodule
